// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst arbiter that shares one FIFO write port among PORTS
// requesters. A grant is held for a whole burst (or up to MAX_BEATS beats),
// and the granted port index travels with every beat on M_ID.
module fifo_burst_arbiter #(
  parameter int unsigned PORTS     = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IDW       = 2,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic [PORTS*WIDTH-1:0] S_DATA,
  input  logic [PORTS-1:0]       S_VALID,
  input  logic [PORTS-1:0]       S_LAST,
  output logic [PORTS-1:0]       S_READY,
  output logic [WIDTH-1:0]       M_DATA,
  output logic [IDW-1:0]         M_ID,
  output logic                   M_LAST,
  output logic                   M_VALID,
  input  logic                   M_READY,
  output logic                   BUSY,
  output logic                   CAP_HIT
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state_q;
  logic [IDW-1:0] g_q;
  logic [IDW-1:0] last_q;
  logic [7:0]     cnt_q;
  logic           cap_q;
  logic [IDW-1:0] win_d;
  logic           cap_end;
  logic           xfer;

  // Winner: first requesting port scanning last+1, last+2, ... modulo PORTS.
  always_comb begin
    int unsigned idx;
    logic        found;
    win_d = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= PORTS; k++) begin
      idx = (32'(last_q) + k) % PORTS;
      if (!found && S_VALID[idx]) begin
        win_d = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  assign cap_end = (cnt_q == 8'(MAX_BEATS - 1));

  // Zero-latency pass-through from the granted port while a burst is held.
  always_comb begin
    S_READY = '0;
    M_VALID = 1'b0;
    M_DATA  = '0;
    M_LAST  = 1'b0;
    if (state_q == BURST) begin
      M_VALID        = S_VALID[g_q];
      M_DATA         = S_DATA[32'(g_q)*WIDTH +: WIDTH];
      M_LAST         = S_LAST[g_q] | cap_end;
      S_READY[g_q]   = M_READY;
    end
  end

  assign xfer    = M_VALID & M_READY;
  assign M_ID    = g_q;
  assign BUSY    = (state_q == BURST);
  assign CAP_HIT = cap_q;

  // Arbitration / burst-hold FSM with beat counter and cap-cut pulse.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= IDW'(PORTS - 1);
      cnt_q   <= '0;
      cap_q   <= 1'b0;
    end else begin
      cap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|S_VALID) begin
            g_q     <= win_d;
            cnt_q   <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            cnt_q <= cnt_q + 8'd1;
            if (M_LAST) begin
              last_q  <= g_q;
              state_q <= IDLE;
              cap_q   <= ~S_LAST[g_q];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Randomized bench for fifo_burst_arbiter: per-port burst generators feed a
// scoreboard of expected beats; a negedge monitor checks arbitration order,
// data routing, burst boundaries, the beat cap and the CAP_HIT pulse.
module tb_fifo_burst_arbiter;
  localparam int P  = 4;
  localparam int W  = 32;
  localparam int IW = 2;
  localparam int MB = 4;

  logic           CLK = 1'b0;
  logic           RESETn;
  logic [P*W-1:0] S_DATA;
  logic [P-1:0]   S_VALID, S_LAST, S_READY;
  logic [W-1:0]   M_DATA;
  logic [IW-1:0]  M_ID;
  logic           M_LAST, M_VALID, M_READY, BUSY, CAP_HIT;

  always #5 CLK = ~CLK;

  fifo_burst_arbiter #(.PORTS(P), .WIDTH(W), .IDW(IW), .MAX_BEATS(MB)) dut (
    .CLK(CLK), .RESETn(RESETn), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_LAST(S_LAST), .S_READY(S_READY), .M_DATA(M_DATA), .M_ID(M_ID),
    .M_LAST(M_LAST), .M_VALID(M_VALID), .M_READY(M_READY), .BUSY(BUSY),
    .CAP_HIT(CAP_HIT)
  );

  typedef struct packed {logic [W-1:0] d; logic l;} beat_t;

  beat_t      src[P][$];
  beat_t      expq[P][$];
  int         errors = 0;
  int         checks = 0;
  logic       mon_en = 1'b0;
  logic [P-1:0] acc = '0;

  // Reference: who holds the FIFO and how many beats it has delivered.
  bit m_busy;
  int m_g, m_last, m_cnt;
  bit m_cap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT against the reference each cycle, pop on transfers.
  always @(negedge CLK) begin
    beat_t        h;
    bit           eff_last;
    int           win;
    logic [P-1:0] er;
    if (mon_en) begin
      acc = S_VALID & S_READY;
      if (!m_busy) begin
        chk("idle_busy", 64'(BUSY), 0);
        chk("idle_mvalid", 64'(M_VALID), 0);
        chk("idle_sready", 64'(S_READY), 0);
        chk("cap_hit", 64'(CAP_HIT), 64'(m_cap));
        chk("idle_mid", 64'(M_ID), 64'(m_g));
        m_cap = 0;
        if (|S_VALID) begin
          win = -1;
          for (int k = 1; k <= P; k++)
            if (win < 0 && S_VALID[(m_last + k) % P]) win = (m_last + k) % P;
          m_g = win; m_cnt = 0; m_busy = 1;
        end
      end else begin
        er = '0;
        if (M_READY) er[m_g] = 1'b1;
        chk("burst_busy", 64'(BUSY), 1);
        chk("burst_mid", 64'(M_ID), 64'(m_g));
        chk("mvalid", 64'(M_VALID), 64'(S_VALID[m_g]));
        chk("sready", 64'(S_READY), 64'(er));
        chk("burst_cap", 64'(CAP_HIT), 0);
        if (S_VALID[m_g]) begin
          if (expq[m_g].size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty at %0t: port %0d presents beat, expected none", $time, m_g);
          end else begin
            h = expq[m_g][0];
            eff_last = h.l || (m_cnt == MB - 1);
            chk("mdata", 64'(M_DATA), 64'(h.d));
            chk("mlast", 64'(M_LAST), 64'(eff_last));
            if (M_READY) begin
              void'(expq[m_g].pop_front());
              m_cnt++;
              if (eff_last) begin
                m_busy = 0; m_last = m_g; m_cap = !h.l;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int    len, total, done;
    beat_t b;
    RESETn = 1'b0; S_VALID = '1; S_LAST = '0; S_DATA = '0; M_READY = 1'b1;
    m_busy = 0; m_g = 0; m_last = P - 1; m_cnt = 0; m_cap = 0;
    #12;
    chk("rst_busy", 64'(BUSY), 0);
    chk("rst_mvalid", 64'(M_VALID), 0);
    chk("rst_sready", 64'(S_READY), 0);
    chk("rst_mid", 64'(M_ID), 0);
    chk("rst_cap", 64'(CAP_HIT), 0);
    S_VALID = '0;
    @(posedge CLK); #1;
    RESETn = 1'b1;
    mon_en = 1'b1;

    done = 0;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(posedge CLK); #1;
      for (int p = 0; p < P; p++) begin
        if (acc[p] && src[p].size() > 0) void'(src[p].pop_front());
        if (cyc < 1500 && src[p].size() == 0 && $urandom_range(0, 2) == 0) begin
          len = $urandom_range(1, 7);
          for (int i = 0; i < len; i++) begin
            b.d = $urandom; b.l = (i == len - 1);
            src[p].push_back(b); expq[p].push_back(b);
          end
        end
        if (src[p].size() > 0 && $urandom_range(0, 3) != 0) begin
          S_VALID[p] = 1'b1;
          S_DATA[p*W +: W] = src[p][0].d;
          S_LAST[p] = src[p][0].l;
        end else begin
          S_VALID[p] = 1'b0;
          S_DATA[p*W +: W] = $urandom;
          S_LAST[p] = 1'($urandom_range(0, 1));
        end
      end
      M_READY = ($urandom_range(0, 3) != 0);
      total = 0;
      for (int p = 0; p < P; p++) total += src[p].size();
      if (cyc >= 1500 && total == 0) done = 1;
    end
    chk("drain_src", 64'(total), 0);
    S_VALID = '0;
    repeat (3) @(posedge CLK);
    #1;
    total = 0;
    for (int p = 0; p < P; p++) total += expq[p].size();
    chk("drain_exp", 64'(total), 0);

    // Reset in beat 2 of a port-2 burst, then port 0 has first priority.
    mon_en = 1'b0;
    @(posedge CLK); #1;
    S_VALID = 4'b0100; S_LAST = '0; M_READY = 1'b1;
    S_DATA[2*W +: W] = 32'hA0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    S_DATA[2*W +: W] = 32'hA1;
    chk("mid_busy", 64'(BUSY), 1);
    chk("mid_mid", 64'(M_ID), 2);
    #2 RESETn = 1'b0;
    #1;
    chk("arst_mvalid", 64'(M_VALID), 0);
    chk("arst_sready", 64'(S_READY), 0);
    chk("arst_busy", 64'(BUSY), 0);
    chk("arst_mid", 64'(M_ID), 0);
    S_VALID = '0;
    @(posedge CLK); #1;
    RESETn = 1'b1; S_VALID = '1; S_LAST = '1;
    @(negedge CLK);
    chk("post_idle", 64'(BUSY), 0);
    @(negedge CLK);
    chk("post_busy", 64'(BUSY), 1);
    chk("post_mid", 64'(M_ID), 0);
    S_VALID = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
